// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and the
// expected-parity helper used by the receiver (and by TX-side logic).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Parity bit a transmitter should send for this data word. Unused upper
    // bits must be zero so that narrow words can share the 9-bit argument.
    function automatic logic expected_parity(input logic [8:0] data, input int mode);
        if (mode == PARITY_ODD)
            return ~(^data);
        else
            return ^data;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous, idle-high input line.
// Resets to 1 so a line in reset never looks like a start bit.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver. The FSM and counters step only on
// sample_tick; each received frame is reported with a one-clk rx_valid pulse
// together with its parity and framing error flags.
module uart_rx_param #(
    parameter int SAMPLE_RATE = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    import uart_pkg::*;

    localparam int TW = $clog2(SAMPLE_RATE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_HALF = TW'(SAMPLE_RATE / 2 - 1);
    localparam logic [TW-1:0] TICK_FULL = TW'(SAMPLE_RATE - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    state_t               state, state_nxt;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_err_q;
    logic                 frm_err_q;
    logic                 line_seen_high;
    logic                 rx_s;

    logic                 mid_start;
    logic                 mid_bit;
    logic                 last_data;
    logic                 last_stop;
    logic                 frm_err_now;
    logic [8:0]           par_data;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    assign mid_start   = (tick_cnt == TICK_HALF);
    assign mid_bit     = (tick_cnt == TICK_FULL);
    assign last_data   = (bit_cnt == LAST_DATA);
    assign last_stop   = (bit_cnt == LAST_STOP);
    // Framing error including the stop bit being sampled right now.
    assign frm_err_now = frm_err_q | ~rx_s;
    assign par_data    = 9'(shreg);

    // State register, advanced only on sample ticks.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else if (sample_tick)
            state <= state_nxt;
    end

    // Next-state decode; a start is accepted only once the line has been
    // seen high, so a held-low break cannot retrigger reception.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!rx_s && line_seen_high) state_nxt = START;
            START:   if (mid_start) state_nxt = rx_s ? IDLE : DATA;
            DATA:    if (mid_bit && last_data)
                         state_nxt = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
            PARITY:  if (mid_bit) state_nxt = STOP;
            STOP:    if (mid_bit && last_stop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state != IDLE);
    end

    // Counters, shift register, error accumulation and the output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt       <= '0;
            bit_cnt        <= '0;
            shreg          <= '0;
            par_err_q      <= 1'b0;
            frm_err_q      <= 1'b0;
            line_seen_high <= 1'b0;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
            parity_err     <= 1'b0;
            frame_err      <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (sample_tick) begin
                case (state)
                    IDLE: begin
                        tick_cnt <= '0;
                        if (rx_s) begin
                            line_seen_high <= 1'b1;
                        end else if (line_seen_high) begin
                            par_err_q <= 1'b0;
                            frm_err_q <= 1'b0;
                        end
                    end
                    START: begin
                        if (mid_start) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (mid_bit) begin
                            shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
                            tick_cnt <= '0;
                            bit_cnt  <= last_data ? '0 : bit_cnt + 1'b1;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        if (mid_bit) begin
                            par_err_q <= (rx_s != expected_parity(par_data, PARITY_MODE));
                            tick_cnt  <= '0;
                            bit_cnt   <= '0;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (mid_bit) begin
                            frm_err_q <= frm_err_now;
                            tick_cnt  <= '0;
                            bit_cnt   <= bit_cnt + 1'b1;
                            if (last_stop) begin
                                bit_cnt    <= '0;
                                rx_data    <= shreg;
                                parity_err <= par_err_q;
                                frame_err  <= frm_err_now;
                                rx_valid   <= 1'b1;
                                if (frm_err_now)
                                    line_seen_high <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised UART receiver, the next generation of the team's simple receiver.
- Single clock domain; oversampled by a one-clk-wide `sample_tick` enable from the shared baud generator.
- Configurable data width, parity (none/odd/even) and 1 or 2 stop bits.
- Flags parity and framing errors, rejects false starts, and presents each frame as a one-cycle `rx_valid` pulse to the downstream FIFO/controller.

Parameters:
- SAMPLE_RATE, 16: sample_tick pulses per bit period. Even, >=4.
- DATA_BITS, 8: data bits per frame, 5..9, LSB first.
- PARITY_MODE, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sample_tick  in  1  oversample enable, one clk wide, SAMPLE_RATE per bit
- rx  in  1  asynchronous serial line, idle high
- rx_data  out  DATA_BITS  last received data word
- rx_valid  out  1  one-clk pulse: rx_data, parity_err and frame_err are valid
- parity_err  out  1  parity mismatch in the last frame; held until the next rx_valid
- frame_err  out  1  a stop bit was sampled low in the last frame; held until the next rx_valid
- busy  out  1  high in every state except IDLE

Behaviour:
- Clocking and reset:
  - One clock (clk); reset is synchronous and active-high.
  - Reset values: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, busy=0, state=IDLE, counters=0, synchroniser flops=1.
  - Reset asserted mid-frame aborts the frame; no rx_valid is produced for it.
- Synchroniser: `rx` passes through 2 flops to give `rx_s`. All decisions use `rx_s`.
- Stepping: the FSM and counters advance only on clk edges where sample_tick=1. Otherwise all state is frozen, except that rx_valid self-clears.
- Counters:
  - tick_cnt: $clog2(SAMPLE_RATE) bits.
  - bit_cnt: $clog2(DATA_BITS+1) bits.
  - shift register: DATA_BITS wide.
- FSM states and transitions:
  - IDLE: if rx_s=0 on a tick -> START, tick_cnt=0.
  - START: count ticks. At tick_cnt = SAMPLE_RATE/2-1 (mid start bit):
    - rx_s=1 -> false start, return to IDLE, no output.
    - rx_s=0 -> DATA, tick_cnt=0, bit_cnt=0.
  - DATA: at tick_cnt = SAMPLE_RATE-1 (mid-bit), shift rx_s in LSB first (new bit enters at MSB, shift right), clear tick_cnt, increment bit_cnt. After DATA_BITS samples -> PARITY if PARITY_MODE!=0, else STOP.
  - PARITY: at mid-bit, sample the parity bit. The error is computed as:
    - odd: parity_bit XNOR (^data) -> error
    - even: parity_bit XOR (^data) -> error
    - Result is stored internally; then -> STOP.
  - STOP: sample each of STOP_BITS stop bits at mid-bit. Any low sample sets the internal frame error. After the last stop sample -> IDLE at mid-stop-bit, so a start bit immediately following is caught.
- Output update and latency:
  - On the clk edge that samples the last stop bit, register rx_data, parity_err and frame_err together, and assert rx_valid for exactly one clk.
  - Latency: rx_valid is high in the clk cycle immediately after that edge.
- Boundary conditions:
  - Frames with errors still produce rx_valid, with the error flag set; rx_data carries the shifted bits.
  - Break condition (line held low): frame_err=1, rx_data=0, then START is re-entered only after rx_s has returned high and fallen again. This requires a wait in IDLE for a high sample; IDLE holds a "line_seen_high" bit, cleared on frame_err and set on rx_s=1.
  - A glitch shorter than SAMPLE_RATE/2 ticks during IDLE is rejected as a false start.
  - Counters never wrap mid-bit; tick_cnt wraps only by explicit clear.

Decomposition:
- Shared package uart_pkg:
  - state enum localparams IDLE, START, DATA, PARITY, STOP;
  - PARITY_NONE/ODD/EVEN constants;
  - a function computing expected parity from data and mode.
- One sub-module: uart_rx_sync, the 2-flop synchroniser with reset value 1. Reusable by the TX loopback bench and other inputs.
- FSM, counters and shift register stay in uart_rx_param.

Test Plan:
Common bench setup: SAMPLE_RATE=16, sample_tick every 4 clk.
1. Defaults, send 0xA5, 1 stop -> one rx_valid pulse, rx_data=0xA5, parity_err=0, frame_err=0, busy low again within 8 ticks of mid-stop.
2. PARITY_MODE=2, send 0x37 with correct parity bit 1, then 0x37 with parity bit 0 -> first rx_valid parity_err=0, second rx_valid parity_err=1, rx_data=0x37 both.
3. DATA_BITS=7, STOP_BITS=2, send 0x55 with second stop bit driven low -> rx_data=0x55, frame_err=1.
4. rx low pulse of 5 ticks in IDLE -> no rx_valid, busy returns 0 at tick 8; a following valid 0x3C frame is received correctly.
5. Line held low for 20 bit periods -> exactly one rx_valid, rx_data=0x00, frame_err=1; no further rx_valid until the line goes high and a new start bit arrives.
6. Reset asserted during data bit 4 of 0xFF -> all outputs 0 next clk, no rx_valid; the next frame 0x81 is received correctly.
